// File: rtl/serial_comparator.sv
// Bit-serial unsigned magnitude comparator: walks both operands MSB-first and
// stops at the first differing bit, reporting lesser/greater/equal with a done pulse.
module serial_comparator #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         lesser,
    output logic         greater,
    output logic         equal
);

    // Wide enough to hold the value N itself, so the load never wraps.
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   a_sh_q, a_sh_d;
    logic [N-1:0]   b_sh_q, b_sh_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           lesser_q, lesser_d;
    logic           greater_q, greater_d;
    logic           equal_q, equal_d;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = done_q;
        lesser_d  = lesser_q;
        greater_d = greater_q;
        equal_d   = equal_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    cnt_d   = CW'(N);
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_q << 1;
                cnt_d  = cnt_q - CW'(1);
                if (a_sh_q[N-1] != b_sh_q[N-1]) begin
                    greater_d = a_sh_q[N-1];
                    lesser_d  = ~a_sh_q[N-1];
                    equal_d   = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else if (cnt_q == CW'(1)) begin
                    greater_d = 1'b0;
                    lesser_d  = 1'b0;
                    equal_d   = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            lesser_q  <= 1'b0;
            greater_q <= 1'b0;
            equal_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            lesser_q  <= lesser_d;
            greater_q <= greater_d;
            equal_q   <= equal_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign lesser  = lesser_q;
    assign greater = greater_q;
    assign equal   = equal_q;

endmodule
